// File: rtl/vae_forward_bram.sv
// Fixed-point (Q6.10) VAE forward engine: 9-input encoder to two latents, then a
// 9-output decoder with hard-sigmoid activation, all operands held in on-chip BRAMs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready high, waiting for start
// S_ENC   | issue xin/wb2_m/wb2_v reads at addresses 8..0, accumulate
// S_LATCH | fold in the last encoder term, saturate and register latents
// S_DEC   | issue wb3 reads at addresses 8..0, write xout one cycle later
// S_DONE  | last xout write, done pulse
module vae_forward_bram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  output logic        ready,
  input  logic        start,
  output logic        done,
  input  logic        wb2_m_ena,
  input  logic [7:0]  wb2_m_wea,
  input  logic [3:0]  wb2_m_addra,
  input  logic [63:0] wb2_m_dina,
  input  logic        wb2_v_ena,
  input  logic [7:0]  wb2_v_wea,
  input  logic [3:0]  wb2_v_addra,
  input  logic [63:0] wb2_v_dina,
  input  logic        wb3_ena,
  input  logic [7:0]  wb3_wea,
  input  logic [3:0]  wb3_addra,
  input  logic [63:0] wb3_dina,
  input  logic        xin_ena,
  input  logic [7:0]  xin_wea,
  input  logic [3:0]  xin_addra,
  input  logic [15:0] xin_dina,
  input  logic        xout_enb,
  input  logic [3:0]  xout_addrb,
  output logic [15:0] xout_doutb
);

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_LATCH, S_DEC, S_DONE} state_t;

  localparam logic [3:0] LAST_ADDR = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  tmr_q, tmr_d;

  logic [63:0] wb2_m_mem [16];
  logic [63:0] wb2_v_mem [16];
  logic [63:0] wb3_mem   [16];
  logic [15:0] xin_mem   [16];
  logic [15:0] xout_mem  [16];

  logic [63:0] m_q, v_q, w3_q;
  logic [15:0] x_q;
  logic [3:0]  rd_idx;
  logic        vld_enc, vld_dec;

  logic signed [31:0] acc1m_q, acc2m_q, acc1v_q, acc2v_q;
  logic signed [31:0] acc1m_d, acc2m_d, acc1v_d, acc2v_d;
  logic signed [31:0] bias1m, bias2m, bias1v, bias2v;
  logic signed [15:0] z1_q, z2_q, z1v_q, z2v_q;
  logic signed [31:0] s_dec;
  logic [15:0]        a_dec;

  function automatic logic signed [31:0] qmul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return p >>> 10;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7FFF;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  function automatic logic [15:0] hard_sigmoid(input logic signed [31:0] s);
    logic signed [31:0] h;
    h = (s >>> 2) + 32'sd512;
    if (h < 32'sd0)
      return 16'h0000;
    else if (h > 32'sd1024)
      return 16'h0400;
    else
      return h[15:0];
  endfunction

  // Host write ports, byte-enabled; no reset on array contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (wb2_m_ena && wb2_m_wea[k]) wb2_m_mem[wb2_m_addra][8*k +: 8] <= wb2_m_dina[8*k +: 8];
      if (wb2_v_ena && wb2_v_wea[k]) wb2_v_mem[wb2_v_addra][8*k +: 8] <= wb2_v_dina[8*k +: 8];
      if (wb3_ena && wb3_wea[k])     wb3_mem[wb3_addra][8*k +: 8]     <= wb3_dina[8*k +: 8];
    end
    for (int k = 0; k < 2; k++) begin
      if (xin_ena && xin_wea[k]) xin_mem[xin_addra][8*k +: 8] <= xin_dina[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      m_q  <= wb2_m_mem[tmr_q];
      v_q  <= wb2_v_mem[tmr_q];
      x_q  <= xin_mem[tmr_q];
      w3_q <= wb3_mem[tmr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else if (clr) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Reads are issued from the top address down; terminal count 0 ends a phase.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ENC;
          tmr_d   = LAST_ADDR;
        end
      end
      S_ENC: begin
        if (tmr_q == 4'd0) state_d = S_LATCH;
        else               tmr_d   = tmr_q - 4'd1;
      end
      S_LATCH: begin
        state_d = S_DEC;
        tmr_d   = LAST_ADDR;
      end
      S_DEC: begin
        if (tmr_q == 4'd0) state_d = S_DONE;
        else               tmr_d   = tmr_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_enc <= 1'b0;
      vld_dec <= 1'b0;
      rd_idx  <= '0;
    end else if (clr) begin
      vld_enc <= 1'b0;
      vld_dec <= 1'b0;
      rd_idx  <= '0;
    end else if (en) begin
      vld_enc <= (state_q == S_ENC);
      vld_dec <= (state_q == S_DEC);
      rd_idx  <= tmr_q;
    end
  end

  // Biases live only at address 0; other addresses' bias fields are ignored.
  always_comb begin
    bias1m = '0;
    bias2m = '0;
    bias1v = '0;
    bias2v = '0;
    if (rd_idx == 4'd0) begin
      bias1m = {{16{m_q[31]}}, m_q[31:16]};
      bias2m = {{16{m_q[15]}}, m_q[15:0]};
      bias1v = {{16{v_q[31]}}, v_q[31:16]};
      bias2v = {{16{v_q[15]}}, v_q[15:0]};
    end
    acc1m_d = acc1m_q + qmul(m_q[63:48], x_q) + bias1m;
    acc2m_d = acc2m_q + qmul(m_q[47:32], x_q) + bias2m;
    acc1v_d = acc1v_q + qmul(v_q[63:48], x_q) + bias1v;
    acc2v_d = acc2v_q + qmul(v_q[47:32], x_q) + bias2v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1m_q <= '0;
      acc2m_q <= '0;
      acc1v_q <= '0;
      acc2v_q <= '0;
    end else if (clr || (en && state_q == S_IDLE && start)) begin
      acc1m_q <= '0;
      acc2m_q <= '0;
      acc1v_q <= '0;
      acc2v_q <= '0;
    end else if (en && vld_enc) begin
      acc1m_q <= acc1m_d;
      acc2m_q <= acc2m_d;
      acc1v_q <= acc1v_d;
      acc2v_q <= acc2v_d;
    end
  end

  // The address-0 term arrives during LATCH, so latch from the next-sum path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z1_q  <= '0;
      z2_q  <= '0;
      z1v_q <= '0;
      z2v_q <= '0;
    end else if (en && !clr && state_q == S_LATCH) begin
      z1_q  <= sat16(acc1m_d);
      z2_q  <= sat16(acc2m_d);
      z1v_q <= sat16(acc1v_d);
      z2v_q <= sat16(acc2v_d);
    end
  end

  always_comb begin
    s_dec = {{16{w3_q[31]}}, w3_q[31:16]} + qmul(w3_q[63:48], z1_q) + qmul(w3_q[47:32], z2_q);
    a_dec = hard_sigmoid(s_dec);
  end

  always_ff @(posedge clk) begin
    if (en && !clr && vld_dec) xout_mem[rd_idx] <= a_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        xout_doutb <= '0;
    else if (xout_enb) xout_doutb <= xout_mem[xout_addrb];
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE) && en && !clr;

  // Variance latents are kept for a later sampling stage; nothing reads them yet.
  logic unused_ok;
  assign unused_ok = ^{xin_wea[7:2], w3_q[15:0], z1v_q, z2v_q};

endmodule

// File: tb/tb_vae_forward_bram.sv
// Scoreboard bench for vae_forward_bram: parameters are loaded through the host
// ports, a reference model queues expected xout values, readback pops and compares.
module tb_vae_forward_bram;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, start;
  logic        ready, done;
  logic        wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena;
  logic [7:0]  wb2_m_wea, wb2_v_wea, wb3_wea, xin_wea;
  logic [3:0]  wb2_m_addra, wb2_v_addra, wb3_addra, xin_addra;
  logic [63:0] wb2_m_dina, wb2_v_dina, wb3_dina;
  logic [15:0] xin_dina;
  logic        xout_enb;
  logic [3:0]  xout_addrb;
  logic [15:0] xout_doutb;

  int checks = 0;
  int errors = 0;
  localparam int LAT = 19;

  logic signed [15:0] w1 [9], w2 [9], w31 [9], w32 [9], b3 [9], xv [9];
  logic signed [15:0] b1, b2;
  logic [15:0] exp_q [$];

  vae_forward_bram dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ready(ready), .start(start), .done(done),
    .wb2_m_ena(wb2_m_ena), .wb2_m_wea(wb2_m_wea), .wb2_m_addra(wb2_m_addra), .wb2_m_dina(wb2_m_dina),
    .wb2_v_ena(wb2_v_ena), .wb2_v_wea(wb2_v_wea), .wb2_v_addra(wb2_v_addra), .wb2_v_dina(wb2_v_dina),
    .wb3_ena(wb3_ena), .wb3_wea(wb3_wea), .wb3_addra(wb3_addra), .wb3_dina(wb3_dina),
    .xin_ena(xin_ena), .xin_wea(xin_wea), .xin_addra(xin_addra), .xin_dina(xin_dina),
    .xout_enb(xout_enb), .xout_addrb(xout_addrb), .xout_doutb(xout_doutb)
  );

  always #5 clk = ~clk;

  function automatic int qmul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 10);
  endfunction

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic zero_params();
    for (int j = 0; j < 9; j++) begin
      w1[j] = 0; w2[j] = 0; w31[j] = 0; w32[j] = 0; b3[j] = 0; xv[j] = 0;
    end
    b1 = 0; b2 = 0;
  endtask

  // Non-zero junk in bias fields at addresses 1..8 must never be summed.
  task automatic load_all();
    for (int j = 0; j < 9; j++) begin
      wb2_m_ena = 1; wb2_v_ena = 1; wb3_ena = 1; xin_ena = 1;
      wb2_m_wea = 8'hFF; wb2_v_wea = 8'hFF; wb3_wea = 8'hFF; xin_wea = 8'hFF;
      wb2_m_addra = 4'(j); wb2_v_addra = 4'(j); wb3_addra = 4'(j); xin_addra = 4'(j);
      wb2_m_dina = {w1[j], w2[j], (j == 0) ? b1 : 16'h7000, (j == 0) ? b2 : 16'h7000};
      wb2_v_dina = {w2[j], w1[j], 16'h1234, 16'h4321};
      wb3_dina   = {w31[j], w32[j], b3[j], 16'hBEEF};
      xin_dina   = xv[j];
      @(negedge clk);
    end
    wb2_m_ena = 0; wb2_v_ena = 0; wb3_ena = 0; xin_ena = 0;
  endtask

  task automatic push_expected();
    int z1, z2, s, h;
    z1 = int'(b1);
    z2 = int'(b2);
    for (int j = 0; j < 9; j++) begin
      z1 += qmul(int'(w1[j]), int'(xv[j]));
      z2 += qmul(int'(w2[j]), int'(xv[j]));
    end
    z1 = sat16(z1);
    z2 = sat16(z2);
    for (int i = 0; i < 9; i++) begin
      s = int'(b3[i]) + qmul(int'(w31[i]), z1) + qmul(int'(w32[i]), z2);
      h = (s >>> 2) + 512;
      if (h < 0) h = 0;
      if (h > 1024) h = 1024;
      exp_q.push_back(16'(h));
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    logic [15:0] last;
    last = 16'h0;
    for (int i = 0; i < 9; i++) begin
      xout_enb = 1; xout_addrb = 4'(i);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty addr %0d got %h expected a queued value", i, xout_doutb);
      end else begin
        e = exp_q.pop_front();
        last = e;
        if (xout_doutb !== e) begin
          errors++;
          $display("FAIL xout[%0d] got %h expected %h", i, xout_doutb, e);
        end
      end
    end
    xout_enb = 0; xout_addrb = 4'd0;
    @(negedge clk);
    checks++;
    if (xout_doutb !== last) begin
      errors++;
      $display("FAIL doutb_hold got %h expected %h", xout_doutb, last);
    end
  endtask

  // Full run: start, bounded wait for done with optional en gap / stray start.
  task automatic do_run(input int gap_at, input int gap_len, input int again_at, input int exp_lat);
    int lat;
    bit got;
    push_expected();
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      if (lat == gap_at) en = 0;
      if (lat == gap_at + gap_len) en = 1;
      start = (lat == again_at);
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_fall got %b expected 0", ready);
        end
      end
      if (done === 1'b1) got = 1;
    end
    start = 0; en = 1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout waited %0d cycles expected done at %0d", lat, exp_lat);
      exp_q.delete();
      return;
    end
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency got %0d expected %0d", lat, exp_lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b ready=%b expected done=0 ready=1", done, ready);
    end
    drain();
  endtask

  task automatic test_reset();
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || xout_doutb !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got ready=%b done=%b dout=%h expected 1 0 0000", ready, done, xout_doutb);
    end
  endtask

  task automatic test_zero_params();
    zero_params();
    for (int j = 0; j < 9; j++) xv[j] = 16'sh0400;
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_clamp_high();
    zero_params();
    for (int j = 0; j < 9; j++) begin
      w1[j] = 16'sh0400; xv[j] = 16'sh0400; w31[j] = 16'sh0100;
    end
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_bias();
    zero_params();
    for (int j = 0; j < 9; j++) b3[j] = 16'shF800;
    load_all();
    do_run(-1, 0, -1, LAT);
    for (int j = 0; j < 9; j++) b3[j] = 16'sh0400;
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_saturation();
    zero_params();
    for (int j = 0; j < 9; j++) begin
      w1[j] = 16'sh7FFF; xv[j] = 16'sh7FFF; w31[j] = 16'sh0400;
    end
    load_all();
    do_run(-1, 0, -1, LAT);
    for (int j = 0; j < 9; j++) w1[j] = 16'sh8000;
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_per_address();
    zero_params();
    b1 = 16'sh0040;
    for (int j = 0; j < 9; j++) begin
      w1[j] = 16'sh0400; xv[j] = 16'(j * 64); w31[j] = 16'sh0100; b3[j] = 16'(j * 256);
    end
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_z2_path();
    zero_params();
    b2 = 16'shFF00;
    for (int j = 0; j < 9; j++) begin
      w2[j] = 16'sh0400; xv[j] = 16'sh0100; w32[j] = 16'sh0200; w31[j] = 16'sh0080;
    end
    load_all();
    do_run(-1, 0, -1, LAT);
  endtask

  task automatic test_start_ignored();
    int extra;
    do_run(-1, 0, 4, LAT);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL extra_run got %0d done pulses expected 0", extra);
    end
  endtask

  task automatic test_clr_abort();
    int seen;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (13) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_ready got %b expected 1", ready);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL clr_done got %0d done pulses expected 0", seen);
    end
  endtask

  task automatic test_en_stall();
    do_run(3, 5, -1, LAT + 5);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    push_expected();
    push_expected();
    for (int r = 0; r < 2; r++) begin
      start = 1;
      @(negedge clk);
      start = 0;
      lat = 0;
      got = 0;
      while (!got && lat < 100) begin
        @(negedge clk);
        lat++;
        if (done === 1'b1) got = 1;
      end
      checks++;
      if (!got || lat != LAT) begin
        errors++;
        $display("FAIL b2b_latency run %0d got %0d done=%b expected %0d", r, lat, got, LAT);
      end
      @(negedge clk);
    end
    drain();
    drain();
  endtask

  task automatic test_reset_mid_run();
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || xout_doutb !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_run got ready=%b done=%b dout=%h expected 1 0 0000", ready, done, xout_doutb);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_run(-1, 0, -1, LAT);
  endtask

  initial begin
    rst_n = 0; en = 1; clr = 0; start = 0;
    wb2_m_ena = 0; wb2_v_ena = 0; wb3_ena = 0; xin_ena = 0;
    wb2_m_wea = 0; wb2_v_wea = 0; wb3_wea = 0; xin_wea = 0;
    wb2_m_addra = 0; wb2_v_addra = 0; wb3_addra = 0; xin_addra = 0;
    wb2_m_dina = 0; wb2_v_dina = 0; wb3_dina = 0; xin_dina = 0;
    xout_enb = 0; xout_addrb = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_zero_params();
    test_clamp_high();
    test_bias();
    test_saturation();
    test_per_address();
    test_z2_path();
    test_start_ignored();
    test_clr_abort();
    test_en_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
